// File: rtl/ber_sync_rx_pkg.sv
// Shared state encodings and default sizing for the per-rail PRBS synchronizer / BER meter.
package ber_sync_rx_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_LOCK   = 2'b10
  } state_t;

  localparam int DEPTH_DEF   = 512;
  localparam int NB_DLY_DEF  = 9;
  localparam int WIN_LEN_DEF = 511;
  localparam int NB_WIN_DEF  = 10;
  localparam int NB_CNT_DEF  = 64;

endpackage

// File: rtl/ber_sync_rx_ref_delay_line.sv
// Reference delay line: shift register of past PRBS bits with a combinational delay tap.
module ref_delay_line #(
  parameter int DEPTH  = 512,
  parameter int NB_DLY = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shift,
  input  logic              din,
  input  logic [NB_DLY-1:0] sel,
  output logic              tap
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (shift) begin
      sr <= {sr[DEPTH-2:0], din};
    end
  end

  // Delay 0 is the live bit; delay d reads the pre-shift bit captured d events ago.
  assign tap = (sel == '0) ? din : sr[sel - NB_DLY'(1)];

endmodule

// File: rtl/ber_sync_rx.sv
// Per-rail PRBS synchronizer: fills the reference delay line, sweeps candidate delays,
// then locks and accumulates saturating bit/error counts for BER readout.
module ber_sync_rx
  import ber_sync_rx_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int NB_DLY  = NB_DLY_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int NB_WIN  = NB_WIN_DEF,
  parameter int NB_CNT  = NB_CNT_DEF
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic              i_rx_bit,
  input  logic              i_ref_bit,
  input  logic              i_restart,
  output logic              o_lock,
  output logic [NB_DLY-1:0] o_delay,
  output logic [NB_CNT-1:0] o_bit_count,
  output logic [NB_CNT-1:0] o_err_count,
  output logic [1:0]        o_state
);

  localparam logic [NB_DLY-1:0] DLY_LAST  = NB_DLY'(DEPTH - 1);
  localparam logic [NB_DLY-1:0] FILL_LAST = NB_DLY'(DEPTH - 2);
  localparam logic [NB_WIN-1:0] WIN_LAST  = NB_WIN'(WIN_LEN - 1);

  state_t            state, state_n;
  logic [NB_DLY-1:0] dly, dly_n, best_dly, best_dly_n, fill_cnt, fill_cnt_n;
  logic [NB_WIN-1:0] win_cnt, win_cnt_n, err_win, err_win_n, best_err, best_err_n;
  logic [NB_WIN-1:0] err;
  logic [NB_CNT-1:0] bit_cnt, bit_cnt_n, err_cnt, err_cnt_n;
  logic              evt, tap, mism, better;

  // A restart swallows a coincident strobe completely, including the shift.
  assign evt  = i_enable & i_valid & ~i_restart;
  assign mism = i_rx_bit ^ tap;

  ref_delay_line #(
    .DEPTH  (DEPTH),
    .NB_DLY (NB_DLY)
  ) u_ref_delay_line (
    .clock (clock),
    .reset (i_reset),
    .shift (evt),
    .din   (i_ref_bit),
    .sel   (dly),
    .tap   (tap)
  );

  assign err    = err_win + NB_WIN'(mism);
  assign better = (err < best_err);

  always_comb begin
    state_n    = state;
    dly_n      = dly;
    best_dly_n = best_dly;
    fill_cnt_n = fill_cnt;
    win_cnt_n  = win_cnt;
    err_win_n  = err_win;
    best_err_n = best_err;
    bit_cnt_n  = bit_cnt;
    err_cnt_n  = err_cnt;
    if (i_restart) begin
      state_n    = ST_SEARCH;
      dly_n      = '0;
      best_dly_n = '0;
      win_cnt_n  = '0;
      err_win_n  = '0;
      best_err_n = '1;
      bit_cnt_n  = '0;
      err_cnt_n  = '0;
    end else if (evt) begin
      case (state)
        ST_FILL: begin
          if (fill_cnt == FILL_LAST) begin
            state_n    = ST_SEARCH;
            fill_cnt_n = '0;
            dly_n      = '0;
            win_cnt_n  = '0;
            err_win_n  = '0;
          end else begin
            fill_cnt_n = fill_cnt + NB_DLY'(1);
          end
        end
        ST_SEARCH: begin
          if (win_cnt == WIN_LAST) begin
            win_cnt_n = '0;
            err_win_n = '0;
            if (err == '0) begin
              state_n = ST_LOCK;
            end else begin
              if (better) begin
                best_err_n = err;
                best_dly_n = dly;
              end
              // Last candidate: the winner may be this very trial, so bypass best_dly.
              if (dly == DLY_LAST) begin
                state_n = ST_LOCK;
                dly_n   = better ? dly : best_dly;
              end else begin
                dly_n = dly + NB_DLY'(1);
              end
            end
          end else begin
            win_cnt_n = win_cnt + NB_WIN'(1);
            err_win_n = err;
          end
        end
        ST_LOCK: begin
          if (~&bit_cnt) begin
            bit_cnt_n = bit_cnt + NB_CNT'(1);
            err_cnt_n = err_cnt + NB_CNT'(mism);
          end
        end
        default: state_n = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_FILL;
      dly      <= '0;
      best_dly <= '0;
      fill_cnt <= '0;
      win_cnt  <= '0;
      err_win  <= '0;
      best_err <= '1;
      bit_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      dly      <= dly_n;
      best_dly <= best_dly_n;
      fill_cnt <= fill_cnt_n;
      win_cnt  <= win_cnt_n;
      err_win  <= err_win_n;
      best_err <= best_err_n;
      bit_cnt  <= bit_cnt_n;
      err_cnt  <= err_cnt_n;
    end
  end

  assign o_lock      = (state == ST_LOCK);
  assign o_delay     = dly;
  assign o_bit_count = bit_cnt;
  assign o_err_count = err_cnt;
  assign o_state     = state;

endmodule

// File: tb/tb_ber_sync_rx.sv
// Directed bench for ber_sync_rx: table-driven phases plus hand-written restart/enable/reset sequences.
module tb_ber_sync_rx;

  localparam int DEPTH   = 64;
  localparam int NB_DLY  = 6;
  localparam int WIN_LEN = 63;
  localparam int NB_WIN  = 6;
  localparam int NB_CNT  = 16;
  localparam int NB_SAT  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, valid, rxb, refb, restart;
  logic              lock_a, lock_b;
  logic [NB_DLY-1:0] dly_a, dly_b;
  logic [NB_CNT-1:0] bits_a, errs_a;
  logic [NB_SAT-1:0] bits_b, errs_b;
  logic [1:0]        st_a, st_b;

  ber_sync_rx #(
    .DEPTH(DEPTH), .NB_DLY(NB_DLY), .WIN_LEN(WIN_LEN), .NB_WIN(NB_WIN), .NB_CNT(NB_CNT)
  ) u_dut (
    .clock(clk), .i_reset(rst), .i_enable(en), .i_valid(valid), .i_rx_bit(rxb),
    .i_ref_bit(refb), .i_restart(restart), .o_lock(lock_a), .o_delay(dly_a),
    .o_bit_count(bits_a), .o_err_count(errs_a), .o_state(st_a)
  );

  ber_sync_rx #(
    .DEPTH(DEPTH), .NB_DLY(NB_DLY), .WIN_LEN(WIN_LEN), .NB_WIN(NB_WIN), .NB_CNT(NB_SAT)
  ) u_sat (
    .clock(clk), .i_reset(rst), .i_enable(en), .i_valid(valid), .i_rx_bit(rxb),
    .i_ref_bit(refb), .i_restart(restart), .o_lock(lock_b), .o_delay(dly_b),
    .o_bit_count(bits_b), .o_err_count(errs_b), .o_state(st_b)
  );

  typedef struct {
    int         mode;   // 0: ref delayed 37, 1: same but inverted, 2: ref delayed 5, every 8th inverted
    int         nev;
    logic [1:0] st;
    int         dly;
    int         bits;
    int         errs;
    int         bits4;  // -1 = not checked
    int         errs4;
  } vec_t;

  vec_t tbl [17];
  int   total = 0;
  int   bad   = 0;
  logic hist [0:32767];
  int   nev   = 0;
  logic [8:0] lfsr = 9'h1FF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic rx_for(input int mode, input int n);
    int   d;
    logic r;
    d = (mode == 2) ? 5 : 37;
    r = (n >= d) ? hist[n - d] : 1'b0;
    if (mode == 1) r = ~r;
    if (mode == 2 && (n % 8) == 7) r = ~r;
    return r;
  endfunction

  // One baud strobe every 4 clocks; only accepted events advance the reference history.
  task automatic strobe(input int mode, input logic e, input logic rs);
    logic r, x;
    @(negedge clk);
    if (e && !rs) begin
      r = lfsr[8] ^ lfsr[4];
      lfsr = {lfsr[7:0], r};
      hist[nev] = r;
      x = rx_for(mode, nev);
      nev++;
    end else begin
      r = 1'($urandom);
      x = 1'($urandom);
    end
    refb = r; rxb = x; en = e; restart = rs; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; restart = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_main(input string tag, input logic [1:0] st, input int d,
                            input int b, input int e);
    chk({tag, " state"}, 64'(st_a), 64'(st));
    chk({tag, " lock"},  64'(lock_a), 64'(st == 2'b10));
    chk({tag, " delay"}, 64'(dly_a), 64'(d));
    chk({tag, " bits"},  64'(bits_a), 64'(b));
    chk({tag, " errs"},  64'(errs_a), 64'(e));
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int k = 0; k < tbl[i].nev; k++) strobe(tbl[i].mode, 1'b1, 1'b0);
      check_main($sformatf("row%0d", i), tbl[i].st, tbl[i].dly, tbl[i].bits, tbl[i].errs);
      if (tbl[i].bits4 >= 0) chk($sformatf("row%0d sat bits", i), 64'(bits_b), 64'(tbl[i].bits4));
      if (tbl[i].errs4 >= 0) chk($sformatf("row%0d sat errs", i), 64'(errs_b), 64'(tbl[i].errs4));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b0; rxb = 1'b0; refb = 1'b0; restart = 1'b0;

    // Acquisition at delay 37 from reset
    tbl[0]  = '{0, 62,                2'b00, 0,  0,    0,   0,  0};
    tbl[1]  = '{0, 1,                 2'b01, 0,  0,    0,   0,  0};
    tbl[2]  = '{0, 37*WIN_LEN,        2'b01, 37, 0,    0,   0,  0};
    tbl[3]  = '{0, WIN_LEN-1,         2'b01, 37, 0,    0,   0,  0};
    tbl[4]  = '{0, 1,                 2'b10, 37, 0,    0,   0,  0};
    tbl[5]  = '{0, 1000,              2'b10, 37, 1000, 0,   15, 0};
    // Relock after restart, then fully inverted rx for saturation
    tbl[6]  = '{0, 37*WIN_LEN,        2'b01, 37, 0,    0,   0,  0};
    tbl[7]  = '{0, WIN_LEN-1,         2'b01, 37, 0,    0,   0,  0};
    tbl[8]  = '{0, 1,                 2'b10, 37, 0,    0,   0,  0};
    tbl[9]  = '{1, 15,                2'b10, 37, 15,   15,  15, 15};
    tbl[10] = '{1, 20,                2'b10, 37, 35,   35,  15, 15};
    // Partial search before asynchronous reset
    tbl[11] = '{0, 3*WIN_LEN+10,      2'b01, 3,  0,    0,   0,  0};
    // Full sweep with no zero-error trial, best at delay 5
    tbl[12] = '{2, 62,                2'b00, 0,  0,    0,   0,  0};
    tbl[13] = '{2, 1,                 2'b01, 0,  0,    0,   0,  0};
    tbl[14] = '{2, 63*WIN_LEN+62,     2'b01, 63, 0,    0,   0,  0};
    tbl[15] = '{2, 1,                 2'b10, 5,  0,    0,   0,  0};
    tbl[16] = '{2, 800,               2'b10, 5,  800,  100, 15, -1};

    repeat (3) @(negedge clk);
    check_main("reset", 2'b00, 0, 0, 0);
    chk("reset sat bits", 64'(bits_b), 64'd0);
    rst = 1'b0;

    run_rows(0, 5);

    // Restart coincident with a strobe: event discarded, search restarts without FILL
    strobe(0, 1'b1, 1'b1);
    check_main("restart", 2'b01, 0, 0, 0);
    chk("restart sat lock", 64'(lock_b), 64'd0);
    chk("restart sat bits", 64'(bits_b), 64'd0);

    run_rows(6, 10);

    // Enable low: 25 strobes over 100 cycles change nothing
    repeat (25) strobe(0, 1'b0, 1'b0);
    check_main("disabled", 2'b10, 37, 35, 35);
    chk("disabled sat bits", 64'(bits_b), 64'd15);
    strobe(0, 1'b1, 1'b0);
    check_main("resume", 2'b10, 37, 36, 35);

    // Restart honoured while disabled
    @(negedge clk);
    en = 1'b0; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; en = 1'b1;
    check_main("restart_dis", 2'b01, 0, 0, 0);

    run_rows(11, 11);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_main("async_rst", 2'b00, 0, 0, 0);
    chk("async_rst sat state", 64'(st_b), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_rows(12, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
